alu_bit_serial_seq: RTL and testbench

//  Sequencer that runs a WIDTH-bit ALU operation through one external 1-bit ALU slice, LSB first, one bit per clock.

---
 rtl/alu_bit_serial_seq.sv | 143 ++++++++++++++
 tb/tb_alu_bit_serial_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU sequencer: streams a WIDTH-bit operation through an external
// 1-bit ALU slice, LSB first, one bit per clock, with valid/ready on both sides.
module alu_bit_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [3:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_out_carry;
  logic             r_out_ovf;
  logic             r_out_zero;

  logic             w_last;
  logic             w_is_add;
  logic [WIDTH-1:0] w_shift;

  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_is_add = (r_op[1:0] == 2'b10);
  assign w_shift  = {slice_result, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_RUN;
      S_RUN: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: if (abort || out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands shift right each bit so the slice always sees bit 0; the counter
  // only marks the MSB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_shreg     <= '0;
      r_result    <= '0;
      r_out_carry <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_op;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_carry <= (in_op[1:0] == 2'b10) & (in_op[3] | in_op[2]);
          end
        end
        S_RUN: begin
          if (!abort) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_shreg <= w_shift;
            r_carry <= slice_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result    <= w_shift;
              r_out_zero  <= (w_shift == '0);
              r_out_carry <= w_is_add & slice_cout;
              r_out_ovf   <= w_is_add & (r_carry ^ slice_cout);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_op  = '0;
    if (r_state == S_RUN) begin
      slice_a   = r_a[0];
      slice_b   = r_b[0];
      slice_cin = r_carry;
      slice_op  = r_op;
    end
  end

  assign out_result = r_result;
  assign out_carry  = r_out_carry;
  assign out_ovf    = r_out_ovf;
  assign out_zero   = r_out_zero;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Directed bench for alu_bit_serial_seq with a behavioural 1-bit ALU slice.
module tb_alu_bit_serial_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       abort;
  logic       slice_a;
  logic       slice_b;
  logic       slice_cin;
  logic [3:0] slice_op;
  logic       slice_result;
  logic       slice_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_ovf;
  logic       out_zero;

  int n_checks;
  int n_err;
  int lat;
  logic cin0;

  alu_bit_serial_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .abort(abort),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: optional inversion of each input, then AND/OR/ADD/pass-b.
  logic w_sa, w_sb;
  always_comb begin
    w_sa = slice_a ^ slice_op[3];
    w_sb = slice_b ^ slice_op[2];
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_op[1:0])
      2'b00: slice_result = w_sa & w_sb;
      2'b01: slice_result = w_sa | w_sb;
      2'b10: begin
        slice_result = w_sa ^ w_sb ^ slice_cin;
        slice_cout   = (w_sa & w_sb) | (w_sa & slice_cin) | (w_sb & slice_cin);
      end
      default: slice_result = w_sb;
    endcase
  end

  // Issue one op and count clocks (accept edge included) until out_valid.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    lat = 0;
    cin0 = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (lat == 1) cin0 = slice_cin;
      if (out_valid) break;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    abort = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    n_checks++;
    if ({out_result, out_carry, out_ovf, out_zero} !== 11'd0) begin
      n_err++; $display("FAIL reset_out: result=%h c=%b v=%b z=%b want all 0", out_result, out_carry, out_ovf, out_zero);
    end
    n_checks++;
    if ({slice_a, slice_b, slice_cin, slice_op} !== 7'd0) begin
      n_err++; $display("FAIL reset_slice: a=%b b=%b cin=%b op=%h want 0", slice_a, slice_b, slice_cin, slice_op);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_op(4'b0010, 8'h7F, 8'h01);
    n_checks++;
    if (lat !== 9) begin n_err++; $display("FAIL add_latency: got %0d want 9", lat); end
    n_checks++;
    if ({out_result, out_carry, out_ovf, out_zero} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL add_7f_01: result=%h c=%b v=%b z=%b want 80 0 1 0", out_result, out_carry, out_ovf, out_zero);
    end
    ack();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL add_ack: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_sub();
    run_op(4'b0110, 8'h05, 8'h05);
    n_checks++;
    if (cin0 !== 1'b1) begin n_err++; $display("FAIL sub_cin0: got %b want 1", cin0); end
    n_checks++;
    if ({out_result, out_carry, out_ovf, out_zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL sub_05_05: result=%h c=%b v=%b z=%b want 00 1 0 1", out_result, out_carry, out_ovf, out_zero);
    end
    ack();
  endtask

  task automatic test_logic();
    run_op(4'b0000, 8'hF0, 8'h3C);
    n_checks++;
    if ({out_result, out_carry, out_ovf, out_zero, cin0} !== {8'h30, 4'b0000}) begin
      n_err++; $display("FAIL and_f0_3c: result=%h c=%b v=%b z=%b cin0=%b want 30 0 0 0 0", out_result, out_carry, out_ovf, out_zero, cin0);
    end
    ack();
    run_op(4'b0001, 8'hF0, 8'h3C);
    n_checks++;
    if ({out_result, out_carry, out_ovf, out_zero} !== {8'hFC, 3'b000}) begin
      n_err++; $display("FAIL or_f0_3c: result=%h c=%b v=%b z=%b want fc 0 0 0", out_result, out_carry, out_ovf, out_zero);
    end
    ack();
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    run_op(4'b0010, 8'h12, 8'h34);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a = 8'hAA;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== 8'h46 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_err++; $display("FAIL stall_hold: %0d bad cycles, last valid=%b result=%h ready=%b want 1 46 0", bad, out_valid, out_result, in_ready);
    end
    ack();
    n_checks++;
    if (out_result !== 8'h46 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_after: result=%h valid=%b ready=%b want 46 0 1", out_result, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    in_op = 4'b0010; in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 8'h00 ||
        {slice_a, slice_b, slice_cin, slice_op} !== 7'd0) begin
      n_err++; $display("FAIL reset_mid: ready=%b valid=%b result=%h slice_a=%b op=%h want 1 0 00 0 0", in_ready, out_valid, out_result, slice_a, slice_op);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'b0010, 8'h01, 8'h01);
    n_checks++;
    if (lat !== 9 || out_result !== 8'h02) begin
      n_err++; $display("FAIL reset_fresh: lat=%0d result=%h want 9 02", lat, out_result);
    end
    ack();
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    in_op = 4'b0000; in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_run: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0 || out_result !== 8'h02) begin
      n_err++; $display("FAIL abort_discard: valid cycles=%0d result=%h want 0 02", seen, out_result);
    end
    run_op(4'b0111, 8'hAA, 8'h0F);
    n_checks++;
    if ({out_result, out_carry, out_ovf, out_zero} !== {8'hF0, 3'b000}) begin
      n_err++; $display("FAIL pass_notb: result=%h c=%b v=%b z=%b want f0 0 0 0", out_result, out_carry, out_ovf, out_zero);
    end
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_done: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int t0;
    int t1;
    int n_acc;
    cyc = 0; t0 = -1; t1 = -1; n_acc = 0;
    in_op = 4'b0010; in_a = 8'h10; in_b = 8'h20;
    in_valid = 1'b1; out_ready = 1'b1;
    while (cyc < 40 && n_acc < 2) begin
      if (in_ready) begin
        if (n_acc == 0) t0 = cyc; else t1 = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (t1 - t0 != 10) begin
      n_err++; $display("FAIL b2b_spacing: got %0d clocks want 10", t1 - t0);
    end
    cyc = 0;
    while (cyc < 30 && !in_ready) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_result !== 8'h30 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_result: result=%h ready=%b want 30 1", out_result, in_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_stall();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
